// File: rtl/adder16_reduce_ctrl.sv
// adder16_reduce_ctrl: streams vectors through an external adder tree and accumulates per-job sums
module adder16_reduce_ctrl #(
  parameter int DATA_BITWIDTH = 16,
  parameter int LANES = 16,
  parameter int CNT_BITWIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [CNT_BITWIDTH-1:0]          cfg_num_pass,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*DATA_BITWIDTH-1:0]   in_data,
  output logic [LANES*DATA_BITWIDTH-1:0]   add_in,
  input  logic [DATA_BITWIDTH-1:0]         add_out,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_BITWIDTH-1:0]         out_data,
  output logic                             busy,
  output logic [CNT_BITWIDTH-1:0]          pass_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;
  state_t state;
  logic [CNT_BITWIDTH-1:0] np;
  logic [DATA_BITWIDTH-1:0] acc;
  logic stg_vld, first, accept;
  logic [CNT_BITWIDTH-1:0] np_cfg, cnt_nx;
  assign in_ready = (state == IDLE) || (state == RUN);
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  assign out_data = acc;
  assign np_cfg = (cfg_num_pass == '0) ? CNT_BITWIDTH'(1) : cfg_num_pass;
  assign cnt_nx = pass_cnt + CNT_BITWIDTH'(1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      add_in <= '0;
      stg_vld <= 1'b0;
      first <= 1'b0;
      acc <= '0;
      np <= '0;
      pass_cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      stg_vld <= accept;
      if (accept) add_in <= in_data;
      if (stg_vld) begin
        acc <= (first ? '0 : acc) + add_out;
        first <= 1'b0;
      end
      case (state)
        IDLE: if (in_valid) begin
          np <= np_cfg;
          pass_cnt <= CNT_BITWIDTH'(1);
          first <= 1'b1;
          state <= (np_cfg == CNT_BITWIDTH'(1)) ? DRAIN : RUN;
        end
        RUN: if (in_valid) begin
          pass_cnt <= cnt_nx;
          if (cnt_nx == np) state <= DRAIN;
        end
        DRAIN: begin
          state <= HOLD;
          out_valid <= 1'b1;
        end
        HOLD: if (out_ready) begin
          out_valid <= 1'b0;
          pass_cnt <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder16_reduce_ctrl.sv
// tb_adder16_reduce_ctrl: randomized jobs checked against a job-level sum model plus literal anchors
module tb_adder16_reduce_ctrl;
  localparam int DW = 16, LN = 16, CW = 8, VW = DW * LN;
  logic clk = 0, reset = 1;
  logic [CW-1:0] cfg_num_pass = '0;
  logic in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [VW-1:0] in_data = '0, add_in;
  logic [DW-1:0] add_out, out_data;
  logic [CW-1:0] pass_cnt;
  int total = 0, passes = 0;
  logic [VW-1:0] vecs[$];
  int gaps[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] res;

  adder16_reduce_ctrl dut (
    .clk(clk), .reset(reset), .cfg_num_pass(cfg_num_pass), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .add_in(add_in), .add_out(add_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    add_out = '0;
    for (int i = 0; i < LN; i++) add_out = add_out + add_in[i*DW +: DW];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [VW-1:0] splat(input logic [DW-1:0] v);
    return {LN{v}};
  endfunction

  function automatic logic [DW-1:0] job_sum(input int n);
    longint s = 0;
    for (int b = 0; b < n; b++)
      for (int i = 0; i < LN; i++) s += vecs[b][i*DW +: DW];
    return DW'(s % 65536);
  endfunction

  always @(negedge clk) if (!reset) begin
    if (out_valid && in_ready) chk("cmp_ready_in_hold", 1, 0);
    if (out_valid) begin
      if (exp_q.size() == 0) chk("cmp_spurious_valid", 1, 0);
      else chk("cmp_out_data", out_data, exp_q[0]);
    end
  end

  always @(posedge clk) if (!reset && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());

  task automatic beat(input int b, input int cfg);
    repeat (gaps[b]) @(posedge clk) #1;
    in_valid = 1;
    in_data = vecs[b];
    cfg_num_pass = (b == 0) ? CW'(cfg) : CW'($urandom);
    @(negedge clk);
    chk("beat_in_ready", in_ready, 1);
    chk("beat_pass_cnt", pass_cnt, b);
    @(posedge clk) #1;
    in_valid = 0;
    chk("beat_add_in", add_in, vecs[b]);
  endtask

  task automatic run_job(input int cfg, input int rdelay, output logic [DW-1:0] r);
    int np = (cfg == 0) ? 1 : cfg;
    logic [DW-1:0] e = job_sum(np);
    exp_q.push_back(e);
    for (int b = 0; b < np; b++) beat(b, cfg);
    in_valid = 1;
    in_data = ~vecs[0];
    @(negedge clk);
    chk("drain_out_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 0);
    chk("drain_busy", busy, 1);
    @(negedge clk);
    chk("hold_out_valid", out_valid, 1);
    chk("hold_pass_cnt", pass_cnt, np);
    chk("hold_out_data", out_data, e);
    r = out_data;
    for (int k = 0; k < rdelay; k++) begin
      @(negedge clk);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, e);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk) #1;
    out_ready = 1;
    @(negedge clk);
    chk("hs_in_ready", in_ready, 0);
    @(posedge clk) #1;
    out_ready = 0;
    in_valid = 0;
    chk("idle_out_valid", out_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_pass_cnt", pass_cnt, 0);
    chk("idle_in_ready", in_ready, 1);
  endtask

  task automatic set_job(input int n, input int gmax);
    vecs.delete();
    gaps.delete();
    for (int b = 0; b < n; b++) begin
      logic [VW-1:0] v;
      for (int i = 0; i < LN; i++) v[i*DW +: DW] = DW'($urandom);
      vecs.push_back(v);
      gaps.push_back($urandom_range(0, gmax));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_add_in", add_in, 0);
    chk("rst_out_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    vecs = '{splat(1)}; gaps = '{0};
    run_job(1, 0, res); chk("t1_np1", res, 16'h0010);
    vecs = '{splat(1), splat(2), splat(3), splat(4)}; gaps = '{0, 0, 2, 1};
    run_job(4, 1, res); chk("t2_np4", res, 16'd160);
    vecs = '{splat(5)}; gaps = '{1};
    run_job(0, 0, res); chk("t3_np0", res, 16'd80);
    vecs = '{splat(16'h1000), splat(16'h1000)}; gaps = '{0, 0};
    run_job(2, 0, res); chk("t4_wrap0", res, 16'h0000);
    vecs = '{{240'h0, 16'hFFF0}, {240'h0, 16'h0020}}; gaps = '{0, 1};
    run_job(2, 0, res); chk("t4_wrap10", res, 16'h0010);
    vecs = '{splat(7)}; gaps = '{0};
    run_job(1, 5, res); chk("t5_stall", res, 16'd112);
    vecs = '{splat(9), splat(9), splat(9), splat(9)}; gaps = '{0, 0, 0, 0};
    beat(0, 4);
    beat(1, 4);
    #2 reset = 1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pass_cnt", pass_cnt, 0);
    chk("t6_add_in", add_in, 0);
    @(posedge clk) #1 reset = 0;
    vecs = '{splat(1)}; gaps = '{0};
    run_job(1, 0, res); chk("t6_after_abort", res, 16'h0010);
    for (int j = 0; j < 30; j++) begin
      int cfg = $urandom_range(0, 6);
      set_job((cfg == 0) ? 1 : cfg, 2);
      run_job(cfg, $urandom_range(0, 3), res);
    end
    set_job(255, 0);
    run_job(255, 1, res);
    set_job(3, 1);
    run_job(3, 0, res);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
